// File: rtl/pe3_align_cell.sv
// pe3_align_cell: pipelined 3-sequence alignment cell with saturation, local clamp and best-score tracking
module pe3_align_cell #(
  parameter int W = 12,
  parameter int S2W = 2,
  parameter int S3W = 3,
  parameter logic signed [W-1:0] GAP_PEN = W'(-2),
  parameter bit LOCAL = 1'b0,
  parameter int IDXW = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  input  logic                   i_in_valid,
  input  logic [7*W-1:0]         i_m_in,
  input  logic [7*W-1:0]         i_ixy_in,
  input  logic [7*W-1:0]         i_iyz_in,
  input  logic [7*W-1:0]         i_ixz_in,
  input  logic [7*W-1:0]         i_ix_in,
  input  logic [7*W-1:0]         i_iy_in,
  input  logic [7*W-1:0]         i_iz_in,
  input  logic signed [S2W-1:0]  i_score2ab,
  input  logic signed [S2W-1:0]  i_score2ac,
  input  logic signed [S2W-1:0]  i_score2bc,
  input  logic signed [S3W-1:0]  i_score3abc,
  output logic                   o_out_valid,
  output logic [7*W-1:0]         o_pe_out,
  output logic signed [W-1:0]    o_final_score,
  output logic signed [W-1:0]    o_best_score,
  output logic [IDXW-1:0]        o_best_idx,
  output logic [IDXW-1:0]        o_cell_cnt
);
  localparam logic signed [W-1:0] NEG_INF = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  // In local mode the clamp turns the NEG_INF reset state into 0
  localparam logic signed [W-1:0] RST_VAL = LOCAL ? '0 : NEG_INF;

  function automatic logic signed [W-1:0] max7(input logic [7*W-1:0] v);
    logic signed [W-1:0] m;
    m = v[0 +: W];
    for (int e = 1; e < 7; e++) m = ($signed(v[e*W +: W]) > m) ? v[e*W +: W] : m;
    return m;
  endfunction

  logic [7*W-1:0]      w_in [7];
  logic signed [W:0]   w_add [7];
  logic signed [W:0]   w_sum [7];
  logic signed [W-1:0] w_sat [7];
  logic [7*W-1:0]      w_res;

  logic                r_v1;
  logic signed [W-1:0] r_max [7];
  logic signed [W:0]   r_add [7];
  logic                r_ov;
  logic [7*W-1:0]      r_pe;
  logic signed [W-1:0] r_final;
  logic signed [W-1:0] r_best;
  logic [IDXW-1:0]     r_idx;
  logic [IDXW-1:0]     r_cnt;

  assign w_in  = '{i_m_in, i_ixy_in, i_iyz_in, i_ixz_in, i_ix_in, i_iy_in, i_iz_in};
  assign w_add = '{
    {{(W+1-S3W){i_score3abc[S3W-1]}}, i_score3abc},
    {{(W+1-S2W){i_score2ab[S2W-1]}}, i_score2ab},
    {{(W+1-S2W){i_score2bc[S2W-1]}}, i_score2bc},
    {{(W+1-S2W){i_score2ac[S2W-1]}}, i_score2ac},
    {GAP_PEN[W-1], GAP_PEN},
    {GAP_PEN[W-1], GAP_PEN},
    {GAP_PEN[W-1], GAP_PEN}
  };

  // Stage 1: per-state max over the predecessor vector, addend capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      for (int e = 0; e < 7; e++) begin
        r_max[e] <= NEG_INF;
        r_add[e] <= '0;
      end
    end else begin
      r_v1 <= i_in_valid;
      if (i_in_valid) begin
        for (int e = 0; e < 7; e++) begin
          r_max[e] <= max7(w_in[e]);
          r_add[e] <= w_add[e];
        end
      end
    end
  end

  // Add score with sticky NEG_INF, saturate to W bits, optional local clamp
  always_comb begin
    w_res = '0;
    for (int e = 0; e < 7; e++) begin
      w_sum[e] = {r_max[e][W-1], r_max[e]} + r_add[e];
      w_sat[e] = (r_max[e] == NEG_INF) ? NEG_INF :
                 (w_sum[e][W] != w_sum[e][W-1]) ? (w_sum[e][W] ? NEG_INF : POS_MAX) :
                 w_sum[e][W-1:0];
      w_res[e*W +: W] = (LOCAL && w_sat[e][W-1]) ? '0 : w_sat[e];
    end
  end

  // Stage 2: register cell state vector and its overall maximum
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ov    <= 1'b0;
      r_pe    <= {7{RST_VAL}};
      r_final <= RST_VAL;
    end else begin
      r_ov <= r_v1;
      if (r_v1) begin
        r_pe    <= w_res;
        r_final <= max7(w_res);
      end
    end
  end

  // Tracker: count output beats and keep the first strictly-best score
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_best <= NEG_INF;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (r_ov) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_final > r_best) begin
        r_best <= r_final;
        r_idx  <= r_cnt;
      end
    end
  end

  assign o_out_valid   = r_ov;
  assign o_pe_out      = r_pe;
  assign o_final_score = r_final;
  assign o_best_score  = r_best;
  assign o_best_idx    = r_idx;
  assign o_cell_cnt    = r_cnt;
endmodule

// File: tb/tb_pe3_align_cell.sv
// tb_pe3_align_cell: directed self-checking bench for pe3_align_cell (global and local variants)
module tb_pe3_align_cell;
  localparam int W = 12;
  localparam int S2W = 2;
  localparam int S3W = 3;
  localparam int IDXW = 16;
  localparam int NI = -2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [7*W-1:0] m_in, ixy_in, iyz_in, ixz_in, ix_in, iy_in, iz_in;
  logic signed [S2W-1:0] s2ab, s2ac, s2bc;
  logic signed [S3W-1:0] s3;

  logic ov, l_ov;
  logic [7*W-1:0] pe, l_pe;
  logic signed [W-1:0] fin, l_fin, best, l_best;
  logic [IDXW-1:0] idx, l_idx, cnt, l_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe3_align_cell #(.W(W), .S2W(S2W), .S3W(S3W), .LOCAL(1'b0), .IDXW(IDXW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_in_valid(in_valid),
    .i_m_in(m_in), .i_ixy_in(ixy_in), .i_iyz_in(iyz_in), .i_ixz_in(ixz_in),
    .i_ix_in(ix_in), .i_iy_in(iy_in), .i_iz_in(iz_in),
    .i_score2ab(s2ab), .i_score2ac(s2ac), .i_score2bc(s2bc), .i_score3abc(s3),
    .o_out_valid(ov), .o_pe_out(pe), .o_final_score(fin),
    .o_best_score(best), .o_best_idx(idx), .o_cell_cnt(cnt)
  );

  pe3_align_cell #(.W(W), .S2W(S2W), .S3W(S3W), .LOCAL(1'b1), .IDXW(IDXW)) dut_l (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_in_valid(in_valid),
    .i_m_in(m_in), .i_ixy_in(ixy_in), .i_iyz_in(iyz_in), .i_ixz_in(ixz_in),
    .i_ix_in(ix_in), .i_iy_in(iy_in), .i_iz_in(iz_in),
    .i_score2ab(s2ab), .i_score2ac(s2ac), .i_score2bc(s2bc), .i_score3abc(s3),
    .o_out_valid(l_ov), .o_pe_out(l_pe), .o_final_score(l_fin),
    .o_best_score(l_best), .o_best_idx(l_idx), .o_cell_cnt(l_cnt)
  );

  function automatic logic [7*W-1:0] vec7(input int a0, a1, a2, a3, a4, a5, a6);
    int a [7];
    logic [7*W-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6};
    for (int e = 0; e < 7; e++) r[e*W +: W] = W'(a[e]);
    return r;
  endfunction

  function automatic logic [7*W-1:0] fill(input int v);
    return vec7(v, v, v, v, v, v, v);
  endfunction

  function automatic logic [7*W-1:0] rnd_vec();
    logic [7*W-1:0] r;
    for (int e = 0; e < 7; e++) r[e*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    m_in = fill(NI); ixy_in = fill(NI); iyz_in = fill(NI); ixz_in = fill(NI);
    ix_in = fill(NI); iy_in = fill(NI); iz_in = fill(NI);
    s2ab = '0; s2ac = '0; s2bc = '0; s3 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    m_in = rnd_vec(); ixy_in = rnd_vec(); iyz_in = rnd_vec(); ixz_in = rnd_vec();
    ix_in = rnd_vec(); iy_in = rnd_vec(); iz_in = rnd_vec();
    s2ab = S2W'($urandom); s2ac = S2W'($urandom); s2bc = S2W'($urandom); s3 = S3W'($urandom);
    step();
    step();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", ov); end
    checks++; if (pe !== fill(NI)) begin failures++; $display("FAIL reset_pe_out got %h exp %h", pe, fill(NI)); end
    checks++; if (fin !== W'(NI)) begin failures++; $display("FAIL reset_final got %0d exp %0d", fin, NI); end
    checks++; if (best !== W'(NI)) begin failures++; $display("FAIL reset_best got %0d exp %0d", best, NI); end
    checks++; if (cnt !== '0 || idx !== '0) begin failures++; $display("FAIL reset_cnt_idx got %0d/%0d exp 0/0", cnt, idx); end
    checks++; if (l_pe !== fill(0) || l_fin !== '0) begin failures++; $display("FAIL reset_local got %h/%0d exp all 0", l_pe, l_fin); end
    idle();
    rst_n = 1'b1;
    step();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_flush got %b exp 0", ov); end
  endtask

  task automatic test_basic_m();
    idle();
    m_in = vec7(10, 20, 30, 100, 5, 6, 7);
    s3 = 3; s2ab = 1; s2ac = -1; s2bc = 1;
    in_valid = 1'b1;
    step();
    idle();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL basic_early_valid got %b exp 0", ov); end
    step();
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL basic_valid got %b exp 1", ov); end
    checks++; if (pe !== vec7(103, NI, NI, NI, NI, NI, NI)) begin failures++; $display("FAIL basic_pe_out got %h exp %h", pe, vec7(103, NI, NI, NI, NI, NI, NI)); end
    checks++; if (fin !== 12'sd103) begin failures++; $display("FAIL basic_final got %0d exp 103", fin); end
    checks++; if (l_pe !== vec7(103, 0, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL basic_local_pe got %h exp %h", l_pe, vec7(103, 0, 0, 0, 0, 0, 0)); end
    step();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got %b exp 0", ov); end
    checks++; if (pe !== vec7(103, NI, NI, NI, NI, NI, NI)) begin failures++; $display("FAIL basic_hold got %h exp %h", pe, vec7(103, NI, NI, NI, NI, NI, NI)); end
    checks++; if (best !== 12'sd103 || cnt !== 16'd1 || idx !== 16'd0) begin failures++; $display("FAIL basic_tracker got %0d/%0d/%0d exp 103/1/0", best, cnt, idx); end
  endtask

  task automatic test_saturation();
    idle();
    m_in = fill(2047); s3 = 3;
    ixy_in = fill(2047); s2ab = 1;
    iyz_in = vec7(-100, NI, NI, NI, NI, NI, NI); s2bc = 1;
    ixz_in = fill(-2047); s2ac = -2;
    ix_in = fill(-2047);
    iy_in = vec7(-10, -30, -40, -11, -500, NI, -20);
    iz_in = vec7(1, 5, 2, -3, 0, 4, NI);
    in_valid = 1'b1;
    step();
    idle();
    step();
    checks++; if (pe !== vec7(2047, 2047, -99, NI, NI, -12, 3)) begin failures++; $display("FAIL sat_pe_out got %h exp %h", pe, vec7(2047, 2047, -99, NI, NI, -12, 3)); end
    checks++; if (fin !== 12'sd2047) begin failures++; $display("FAIL sat_final got %0d exp 2047", fin); end
    checks++; if (l_pe !== vec7(2047, 2047, 0, 0, 0, 0, 3)) begin failures++; $display("FAIL sat_local_pe got %h exp %h", l_pe, vec7(2047, 2047, 0, 0, 0, 0, 3)); end
    step();
  endtask

  task automatic test_local();
    idle();
    m_in = vec7(-5, -9, -20, -7, -100, -6, -50);
    s3 = -3; s2ab = 1; s2ac = 1; s2bc = 1;
    in_valid = 1'b1;
    step();
    idle();
    step();
    checks++; if (l_pe !== fill(0) || l_fin !== '0) begin failures++; $display("FAIL local_clamp got %h/%0d exp all 0", l_pe, l_fin); end
    checks++; if (pe !== vec7(-8, NI, NI, NI, NI, NI, NI) || fin !== -12'sd8) begin failures++; $display("FAIL local_global_ref got %h/%0d exp %h/-8", pe, fin, vec7(-8, NI, NI, NI, NI, NI, NI)); end
    step();
  endtask

  task automatic test_back_to_back();
    int sc [4];
    sc = '{50, 80, 80, 20};
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (best !== W'(NI) || cnt !== '0) begin failures++; $display("FAIL clr_idle got %0d/%0d exp %0d/0", best, cnt, NI); end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        m_in = fill(sc[i]);
        in_valid = 1'b1;
      end else idle();
      step();
      if (i >= 1 && i <= 4) begin
        checks++; if (ov !== 1'b1 || fin !== W'(sc[i-1])) begin failures++; $display("FAIL b2b_stream beat %0d got %b/%0d exp 1/%0d", i - 1, ov, fin, sc[i-1]); end
      end
    end
    idle();
    step();
    checks++; if (best !== 12'sd80 || idx !== 16'd1 || cnt !== 16'd4) begin failures++; $display("FAIL b2b_best got %0d/%0d/%0d exp 80/1/4", best, idx, cnt); end
    m_in = fill(90);
    in_valid = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    idle();
    checks++; if (best !== W'(NI) || cnt !== '0 || idx !== '0) begin failures++; $display("FAIL clr_beat got %0d/%0d/%0d exp %0d/0/0", best, cnt, idx, NI); end
    step();
    checks++; if (ov !== 1'b1 || fin !== 12'sd90) begin failures++; $display("FAIL clr_pipe_continues got %b/%0d exp 1/90", ov, fin); end
    step();
    checks++; if (best !== 12'sd90 || cnt !== 16'd1 || idx !== 16'd0) begin failures++; $display("FAIL clr_after got %0d/%0d/%0d exp 90/1/0", best, cnt, idx); end
    m_in = fill(200);
    in_valid = 1'b1;
    step();
    idle();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (best !== W'(NI) || cnt !== '0) begin failures++; $display("FAIL clr_wins got %0d/%0d exp %0d/0", best, cnt, NI); end
    step();
    checks++; if (cnt !== '0) begin failures++; $display("FAIL clr_not_counted got %0d exp 0", cnt); end
  endtask

  task automatic test_mid_reset();
    idle();
    m_in = fill(60);
    in_valid = 1'b1;
    step();
    m_in = fill(70);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    checks++; if (ov !== 1'b0 || cnt !== '0 || best !== W'(NI)) begin failures++; $display("FAIL midrst_state got %b/%0d/%0d exp 0/0/%0d", ov, cnt, best, NI); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL midrst_discard cycle %0d got %b exp 0", i, ov); end
    end
    m_in = fill(33);
    in_valid = 1'b1;
    step();
    idle();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL midrst_early got %b exp 0", ov); end
    step();
    checks++; if (ov !== 1'b1 || fin !== 12'sd33) begin failures++; $display("FAIL midrst_next_beat got %b/%0d exp 1/33", ov, fin); end
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_m();
    test_saturation();
    test_local();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe3_align_cell.md
Name: pe3_align_cell

Overview:
- Parametrised, pipelined 3-sequence affine-free alignment processing element for the systolic array.
- Computes one DP cell per valid beat over seven states: M, Ixy, Iyz, Ixz, Ix, Iy, Iz.
- Each state takes the max over its predecessor cell's seven states, adds a score, then saturates; optional local-alignment clamp.
- Adds valid handshake, configurable width, saturation and NEG_INF propagation, and running best-score and position tracking.

Parameters:
- W, 12, signed score width.
- S2W, 2, signed pairwise score width.
- S3W, 3, signed triple score width.
- GAP_PEN, -2, signed W-bit penalty added to the Ix, Iy and Iz states.
- LOCAL, 0, 1 clamps every state output at 0 (local alignment).
- IDXW, 16, width of the cell counter and index.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous, active-low reset.
- CLR  in  1  synchronous clear of best/counter registers only.
- IN_VALID  in  1  beat qualifier for all data inputs.
- M_IN  in  7*W  predecessor (i-1,j-1,k-1) state vector.
- IXY_IN  in  7*W  predecessor (i-1,j-1,k) state vector.
- IYZ_IN  in  7*W  predecessor (i,j-1,k-1) state vector.
- IXZ_IN  in  7*W  predecessor (i-1,j,k-1) state vector.
- IX_IN  in  7*W  predecessor (i-1,j,k) state vector.
- IY_IN  in  7*W  predecessor (i,j-1,k) state vector.
- IZ_IN  in  7*W  predecessor (i,j,k-1) state vector.
- SCORE2AB, SCORE2AC, SCORE2BC  in  S2W each  signed pairwise scores.
- SCORE3ABC  in  S3W  signed triple score.
- OUT_VALID  out  1  PE_OUT/FINAL_SCORE valid.
- PE_OUT  out  7*W  new cell state vector.
- FINAL_SCORE  out  W  max of the seven PE_OUT elements.
- BEST_SCORE  out  W  largest FINAL_SCORE since reset/CLR.
- BEST_IDX  out  IDXW  cell count at which BEST_SCORE occurred.
- CELL_CNT  out  IDXW  number of OUT_VALID beats since reset/CLR.

Behaviour:
- Vector packing: element e at bits [e*W +: W]. e=0 M, 1 Ixy, 2 Iyz, 3 Ixz, 4 Ix, 5 Iy, 6 Iz.
- Addends per state:
  - M: SCORE3ABC.
  - Ixy: SCORE2AB.
  - Ixz: SCORE2AC.
  - Iyz: SCORE2BC.
  - Ix, Iy, Iz: GAP_PEN.
  - All addends sign-extended to W+1 bits.
- NEG_INF = -2^(W-1).
- Stage 1 (on IN_VALID, registered):
  - Seven signed max7 units, one per input vector.
  - Seven addends captured.
  - v1 <= IN_VALID.
- Stage 2 (registered):
  - sum = max + addend in W+1 bits.
  - If max == NEG_INF, result = NEG_INF (sticky, no addend applied).
  - Otherwise saturate to [NEG_INF, 2^(W-1)-1].
  - If LOCAL=1, negative results become 0; this includes NEG_INF.
  - PE_OUT <= results. FINAL_SCORE <= max7(results) computed combinationally from the stage-2 results.
  - OUT_VALID <= v1.
- Latency: exactly 2 cycles IN_VALID -> OUT_VALID. Throughput 1 cell/cycle; no back-pressure.
- When IN_VALID=0, data registers hold their previous values; only the valid bits advance.
- Tracker (registered, updates the cycle after OUT_VALID):
  - CELL_CNT increments per OUT_VALID and wraps at 2^IDXW-1 -> 0.
  - If FINAL_SCORE > BEST_SCORE (strict), BEST_SCORE <= FINAL_SCORE and BEST_IDX <= CELL_CNT (pre-increment). Ties keep the first occurrence.
- Reset (RST_N=0 at an edge):
  - OUT_VALID=0, v1=0, PE_OUT all NEG_INF (all 0 if LOCAL=1), FINAL_SCORE same value.
  - BEST_SCORE=NEG_INF, BEST_IDX=0, CELL_CNT=0.
  - In-flight beats are discarded.
- Simultaneous events:
  - CLR=1: BEST_SCORE=NEG_INF, BEST_IDX=0, CELL_CNT=0. The pipeline continues.
  - CLR and a tracker update in the same cycle: CLR wins, and that beat is not counted.
  - RST_N has priority over CLR.

Test Plan:
- Reset: drive RST_N=0 for 2 cycles with IN_VALID=1 and random data -> OUT_VALID=0, PE_OUT elements=-2048, BEST_SCORE=-2048, CELL_CNT=0.
- Basic M path:
  - Stimulus (W=12): M_IN={10,20,30,100,5,6,7}, SCORE3ABC=3, all other vectors NEG_INF, one IN_VALID pulse at cycle t.
  - Response: OUT_VALID at t+2 only, PE_OUT[0]=103, other elements=-2048, FINAL_SCORE=103.
- Saturation:
  - IXY_IN all 2047 with SCORE2AB=1 -> PE_OUT[1]=2047.
  - IX_IN all -2047 with GAP_PEN=-2 -> PE_OUT[4]=-2048.
- Local mode (LOCAL=1): M_IN max -5, SCORE3ABC=-3, all others NEG_INF -> PE_OUT[0]=0, every element 0, FINAL_SCORE=0.
- Best tracking:
  - Back-to-back beats with FINAL_SCORE 50, 80, 80, 20 -> BEST_SCORE=80, BEST_IDX=1, CELL_CNT=4.
  - Then CLR with a concurrent valid beat -> BEST_SCORE=-2048, CELL_CNT=0.
- Mid-stream reset: RST_N low for one cycle while two beats are in flight -> neither produces OUT_VALID; the next beat appears 2 cycles after its IN_VALID.
